// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, lock states and symbol helpers.
// Pure combinational helpers; no latency, no flow control.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  function automatic logic is_ctrl_token(input logic [9:0] sym);
    return (sym == CTRL_TOKEN_00) || (sym == CTRL_TOKEN_01) ||
           (sym == CTRL_TOKEN_10) || (sym == CTRL_TOKEN_11);
  endfunction

  function automatic logic [1:0] ctrl_value(input logic [9:0] sym);
    logic [1:0] val;
    case (sym)
      CTRL_TOKEN_01: val = 2'b01;
      CTRL_TOKEN_10: val = 2'b10;
      CTRL_TOKEN_11: val = 2'b11;
      default:       val = 2'b00;
    endcase
    return val;
  endfunction

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
  function automatic logic [7:0] decode_data(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Ones minus zeros of a 10-bit symbol: 2*popcount - 10.
  function automatic logic signed [4:0] sym_disparity(input logic [9:0] sym);
    logic [3:0]        ones;
    logic signed [5:0] diff;
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, sym[i]};
    end
    diff = $signed({1'b0, ones, 1'b0}) - 6'sd10;
    return diff[4:0];
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Two-stage symbol datapath: stage 1 registers and classifies the symbol, stage 2 registers outputs.
// Latency 2 cycles; no backpressure, one symbol accepted every cycle.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic [9:0]        tmds_in,
  input  logic              out_en,
  input  logic              err_in,
  output logic              sym_vld,
  output logic              sym_ctrl,
  output logic [1:0]        sym_ctrl_val,
  output logic signed [4:0] sym_disp,
  output logic [7:0]        data_out,
  output logic [1:0]        ctrl_out,
  output logic              de,
  output logic              err_disp
);

  logic [9:0] sym;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      sym_vld      <= 1'b0;
      sym          <= '0;
      sym_ctrl     <= 1'b0;
      sym_ctrl_val <= '0;
      sym_disp     <= '0;
      data_out     <= '0;
      ctrl_out     <= '0;
      de           <= 1'b0;
      err_disp     <= 1'b0;
    end else begin
      sym_vld      <= 1'b1;
      sym          <= tmds_in;
      sym_ctrl     <= is_ctrl_token(tmds_in);
      sym_ctrl_val <= ctrl_value(tmds_in);
      sym_disp     <= sym_disparity(tmds_in);
      err_disp     <= err_in;
      // out_en is the lock state being registered this edge, so outputs and locked move together.
      if (!out_en) begin
        data_out <= '0;
        ctrl_out <= '0;
        de       <= 1'b0;
      end else if (sym_ctrl) begin
        ctrl_out <= sym_ctrl_val;
        de       <= 1'b0;
      end else if (sym_vld) begin
        data_out <= decode_data(sym);
        de       <= 1'b1;
      end else begin
        de       <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tmds_decoder_dvi.sv
// One DVI TMDS channel decoder with token-based alignment lock and running-disparity check.
// Latency 2 cycles tmds_in to outputs; no backpressure, bitslip is a one-cycle request.
module tmds_decoder_dvi
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS   = 16,
  parameter int unsigned SEARCH_CYCLES = 2048,
  parameter int unsigned SLIP_WAIT     = 8,
  parameter int unsigned DISP_LIMIT    = 16
) (
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de,
  output logic        locked,
  output logic        bitslip,
  output logic        err_disp,
  output logic [15:0] err_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned IDLE_W = $clog2(SEARCH_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam logic signed [8:0] LIM = 9'(DISP_LIMIT);

  logic              sym_vld;
  logic              sym_ctrl;
  logic [1:0]        sym_ctrl_val;
  logic signed [4:0] sym_disp;

  lock_state_t       state;
  logic [RUN_W-1:0]  ctrl_run;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic signed [7:0] acc;

  logic              tok;
  logic              dat;
  logic              run_hit;
  logic              idle_hit;
  logic              lock_nxt;
  logic              err_hit;
  logic [RUN_W-1:0]  run_inc;
  logic [IDLE_W-1:0] idle_inc;
  logic signed [8:0] disp_sum;

  tmds_symbol_decode u_decode (
    .clk_pix      (clk_pix),
    .rst_pix_n    (rst_pix_n),
    .tmds_in      (tmds_in),
    .out_en       (lock_nxt),
    .err_in       (err_hit),
    .sym_vld      (sym_vld),
    .sym_ctrl     (sym_ctrl),
    .sym_ctrl_val (sym_ctrl_val),
    .sym_disp     (sym_disp),
    .data_out     (data_out),
    .ctrl_out     (ctrl_out),
    .de           (de),
    .err_disp     (err_disp)
  );

  always_comb begin
    tok      = sym_vld & sym_ctrl;
    dat      = sym_vld & ~sym_ctrl;
    run_inc  = ctrl_run + RUN_W'(1);
    idle_inc = idle_cnt + IDLE_W'(1);
    run_hit  = tok && (run_inc == RUN_W'(LOCK_TOKENS));
    // Only data symbols can hit the timeout, so a token on the limit cycle always wins.
    idle_hit = dat && (idle_inc == IDLE_W'(SEARCH_CYCLES));
    lock_nxt = ((state == SEARCH) && run_hit) || ((state == LOCKED) && !idle_hit);
    disp_sum = $signed({acc[7], acc}) + $signed({{4{sym_disp[4]}}, sym_disp});
    err_hit  = (state == LOCKED) && dat && ((disp_sum > LIM) || (disp_sum < -LIM));
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state    <= SEARCH;
      ctrl_run <= '0;
      idle_cnt <= '0;
      wait_cnt <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      locked  <= lock_nxt;
      case (state)
        SEARCH: begin
          if (tok) begin
            idle_cnt <= '0;
            if (run_hit) begin
              state    <= LOCKED;
              ctrl_run <= '0;
            end else begin
              ctrl_run <= run_inc;
            end
          end else if (dat) begin
            ctrl_run <= '0;
            if (idle_hit) begin
              state    <= SLIP;
              bitslip  <= 1'b1;
              idle_cnt <= '0;
              wait_cnt <= '0;
            end else begin
              idle_cnt <= idle_inc;
            end
          end
        end
        SLIP: begin
          // Symbols seen here are from the old alignment; ignore them until the deserializer settles.
          if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
            state    <= SEARCH;
            wait_cnt <= '0;
            ctrl_run <= '0;
            idle_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        LOCKED: begin
          if (tok) begin
            idle_cnt <= '0;
          end else if (dat) begin
            if (idle_hit) begin
              state    <= SEARCH;
              idle_cnt <= '0;
              ctrl_run <= '0;
            end else begin
              idle_cnt <= idle_inc;
            end
          end
        end
        default: begin
          state    <= SEARCH;
          ctrl_run <= '0;
          idle_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      acc       <= '0;
      err_count <= '0;
    end else begin
      if ((state != LOCKED) || tok || err_hit) begin
        acc <= '0;
      end else if (dat) begin
        acc <= disp_sum[7:0];
      end
      if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// Bench for tmds_decoder_dvi: random symbol streams against a symbol-level behavioural model.
module tb_tmds_decoder_dvi;

  localparam int LOCK_TOKENS   = 16;
  localparam int SEARCH_CYCLES = 2048;
  localparam int SLIP_WAIT     = 8;
  localparam int DISP_LIMIT    = 16;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n = 1'b0;
  logic [9:0]  tmds_in = '0;
  logic [7:0]  data_out;
  logic [1:0]  ctrl_out;
  logic        de;
  logic        locked;
  logic        bitslip;
  logic        err_disp;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  tmds_decoder_dvi #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_CYCLES(SEARCH_CYCLES),
    .SLIP_WAIT    (SLIP_WAIT),
    .DISP_LIMIT   (DISP_LIMIT)
  ) dut (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .tmds_in  (tmds_in),
    .data_out (data_out),
    .ctrl_out (ctrl_out),
    .de       (de),
    .locked   (locked),
    .bitslip  (bitslip),
    .err_disp (err_disp),
    .err_count(err_count)
  );

  always #5 clk_pix = ~clk_pix;

  // Behavioural model state, one update per symbol.
  bit         m_locked;
  int         m_run, m_idle, m_slip_left, m_acc, m_errs;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  bit         e_de, e_err, e_slip;
  logic [9:0] prev_sym;
  bit         prev_vld;

  function automatic bit ref_token(input logic [9:0] s, output logic [1:0] v);
    v = 2'b00;
    if (s == T00) return 1'b1;
    if (s == T01) begin v = 2'b01; return 1'b1; end
    if (s == T10) begin v = 2'b10; return 1'b1; end
    if (s == T11) begin v = 2'b11; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic int ref_disp(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    logic [1:0] v;
    do s = 10'($urandom_range(0, 1023)); while (ref_token(s, v));
    return s;
  endfunction

  function automatic logic [29:0] got_vec();
    return {locked, de, data_out, ctrl_out, err_disp, bitslip, err_count};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {m_locked, e_de, e_data, e_ctrl, e_err, e_slip, 16'(m_errs)};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_idle = 0; m_slip_left = 0; m_acc = 0; m_errs = 0;
    e_data = '0; e_ctrl = '0; e_de = 0; e_err = 0; e_slip = 0; prev_vld = 0;
  endtask

  task automatic model_symbol(input logic [9:0] s);
    logic [1:0] v;
    bit tok;
    int sum;
    tok = ref_token(s, v);
    e_slip = 0;
    e_err  = 0;
    if (m_slip_left > 0) begin
      m_slip_left--;
      if (m_slip_left == 0) begin m_run = 0; m_idle = 0; end
    end else if (!m_locked) begin
      if (tok) begin
        m_idle = 0;
        m_run++;
        if (m_run == LOCK_TOKENS) begin m_locked = 1; m_run = 0; m_acc = 0; end
      end else begin
        m_run = 0;
        m_idle++;
        if (m_idle == SEARCH_CYCLES) begin e_slip = 1; m_slip_left = SLIP_WAIT; m_idle = 0; end
      end
    end else if (tok) begin
      m_idle = 0;
      m_acc  = 0;
    end else begin
      sum = m_acc + ref_disp(s);
      if (sum > DISP_LIMIT || sum < -DISP_LIMIT) begin
        e_err = 1;
        m_acc = 0;
        if (m_errs < 65535) m_errs++;
      end else begin
        m_acc = sum;
      end
      m_idle++;
      if (m_idle == SEARCH_CYCLES) begin m_locked = 0; m_idle = 0; m_run = 0; m_acc = 0; end
    end
    if (!m_locked) begin
      e_data = '0; e_ctrl = '0; e_de = 0;
    end else if (tok) begin
      e_ctrl = v; e_de = 0;
    end else begin
      e_data = ref_decode(s); e_de = 1;
    end
  endtask

  // Drive one symbol; afterwards the outputs show the symbol driven one step earlier.
  task automatic step(input logic [9:0] s);
    tmds_in = s;
    @(posedge clk_pix);
    #1;
    if (prev_vld) model_symbol(prev_sym);
    prev_sym = s;
    prev_vld = 1;
  endtask

  task automatic apply_reset();
    rst_pix_n = 1'b0;
    repeat (2) begin
      tmds_in = 10'($urandom_range(0, 1023));
      @(posedge clk_pix);
      #1;
    end
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (got_vec() !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", got_vec());
    end
    rst_pix_n = 1'b1;
    step(rand_data());
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_first_step: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i <= LOCK_TOKENS; i++) begin
      step(T00);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lock_step%0d: got %h want %h", i, got_vec(), exp_vec());
      end
      if (i == LOCK_TOKENS - 1) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL lock_early: locked=%b want 0", locked);
        end
      end
      if (i == LOCK_TOKENS) begin
        checks++;
        if ({locked, ctrl_out, de} !== 4'b1000) begin
          errors++;
          $display("FAIL lock_rise: locked/ctrl/de=%b want 1000", {locked, ctrl_out, de});
        end
      end
    end
  endtask

  task automatic test_decode();
    logic [9:0] seq [4] = '{10'b0100000000, 10'b1000000000, T01, T00};
    for (int i = 0; i < 4; i++) begin
      step(seq[i]);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL decode_step%0d: got %h want %h", i, got_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if ({de, data_out} !== 9'h100) begin
          errors++;
          $display("FAIL decode_zero: de/data=%h want 100", {de, data_out});
        end
      end
      if (i == 2) begin
        checks++;
        if ({de, data_out} !== 9'h1FF) begin
          errors++;
          $display("FAIL decode_ff: de/data=%h want 1ff", {de, data_out});
        end
      end
      if (i == 3) begin
        checks++;
        if ({de, ctrl_out} !== 3'b001) begin
          errors++;
          $display("FAIL decode_ctrl01: de/ctrl=%b want 001", {de, ctrl_out});
        end
      end
    end
    for (int i = 0; i < 200; i++) begin
      if (i % 16 == 15) step(T11); else step(rand_data());
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL decode_rand%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_disparity();
    logic [9:0] seq [7];
    bit         want_err [7] = '{0, 0, 0, 0, 1, 0, 0};
    int         base;
    seq = '{T10, 10'b0100000000, 10'b0100000000, 10'b0100000000,
            10'b0100000000, 10'b0100000000, T10};
    base = 0;
    for (int i = 0; i < 7; i++) begin
      step(seq[i]);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL disp_step%0d: got %h want %h", i, got_vec(), exp_vec());
      end
      if (i >= 1) begin
        checks++;
        if (err_disp !== want_err[i]) begin
          errors++;
          $display("FAIL disp_pulse%0d: err_disp=%b want %b", i, err_disp, want_err[i]);
        end
      end
      if (i == 3) base = m_errs;
      if (i == 4) begin
        checks++;
        if (err_count !== 16'(base + 1)) begin
          errors++;
          $display("FAIL disp_count: err_count=%0d want %0d", err_count, base + 1);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    step(T00);
    for (int i = 0; i < SEARCH_CYCLES - 1; i++) begin
      step(rand_data());
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL loss_hold%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    step(T01);
    step(rand_data());
    checks++;
    if ({locked, de, ctrl_out} !== 4'b1001) begin
      errors++;
      $display("FAIL loss_token_wins: locked/de/ctrl=%b want 1001", {locked, de, ctrl_out});
    end
    for (int i = 1; i < SEARCH_CYCLES; i++) begin
      step(rand_data());
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL loss_run%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_before_limit: locked=%b want 1", locked);
    end
    step(T00);
    checks++;
    if ({locked, de} !== 2'b00) begin
      errors++;
      $display("FAIL loss_drop: locked/de=%b want 00", {locked, de});
    end
    step(rand_data());
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL loss_after: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < LOCK_TOKENS + 1; i++) step(T00);
    for (int i = 0; i < 3; i++) step(rand_data());
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL midreset_pre: got %h want %h", got_vec(), exp_vec());
    end
    apply_reset();
    checks++;
    if (got_vec() !== 30'd0) begin
      errors++;
      $display("FAIL midreset_clear: got %h want 0", got_vec());
    end
    rst_pix_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(rand_data());
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_post%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_misalign();
    int slips[$];
    int want [3] = '{SEARCH_CYCLES,
                     2 * SEARCH_CYCLES + SLIP_WAIT,
                     3 * SEARCH_CYCLES + 2 * SLIP_WAIT};
    apply_reset();
    rst_pix_n = 1'b1;
    for (int n = 0; n < want[2] + 10; n++) begin
      step(10'b0101010101);
      if (bitslip === 1'b1) slips.push_back(n);
      if (got_vec() !== exp_vec()) begin
        checks++;
        errors++;
        $display("FAIL misalign_step%0d: got %h want %h", n, got_vec(), exp_vec());
      end else begin
        checks++;
      end
    end
    checks++;
    if (slips.size() != 3) begin
      errors++;
      $display("FAIL misalign_count: pulses=%0d want 3", slips.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (slips[k] != want[k]) begin
          errors++;
          $display("FAIL misalign_pos%0d: cycle=%0d want %0d", k, slips[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_decode();
    test_disparity();
    test_lock_loss();
    test_midreset();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
